// File: rtl/burst_ram_arbiter_if.sv
// BurstRAM-style port bundle: one instance per cache client and one toward the RAM.
// The master drives commands and write beats; the slave returns read beats and busy.
interface burst_ram_arbiter_if #(
    parameter int DEPTH_BITWIDTH = 8,
    parameter int DATA_BITWIDTH  = 64
);
    logic                         cmd;
    logic                         cmd_en;
    logic [DEPTH_BITWIDTH-1:0]    addr;
    logic [DATA_BITWIDTH-1:0]     wr_data;
    logic [DATA_BITWIDTH/8-1:0]   data_mask;
    logic [DATA_BITWIDTH-1:0]     rd_data;
    logic                         rd_data_valid;
    logic                         busy;

    modport master (
        output cmd, cmd_en, addr, wr_data, data_mask,
        input  rd_data, rd_data_valid, busy
    );

    modport slave (
        input  cmd, cmd_en, addr, wr_data, data_mask,
        output rd_data, rd_data_valid, busy
    );
endinterface

// File: rtl/burst_ram_arbiter.sv
// Two-client BurstRAM arbiter: whole bursts are granted to the I-cache or D-cache side,
// with the offer alternating between clients so neither can starve the other.
module burst_ram_arbiter #(
    parameter int DEPTH_BITWIDTH = 8,
    parameter int DATA_BITWIDTH  = 64,
    parameter int BURST_COUNT    = 4
) (
    input  logic clk,
    input  logic rst,
    burst_ram_arbiter_if.slave  c0,
    burst_ram_arbiter_if.slave  c1,
    burst_ram_arbiter_if.master br
);
    localparam int CW = $clog2(BURST_COUNT);
    localparam logic [CW-1:0] LAST_RD = CW'(BURST_COUNT - 1);
    localparam logic [CW-1:0] LAST_WR = CW'(BURST_COUNT - 2);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t          state;
    logic            offer;
    logic            owner;
    logic [CW-1:0]   count;

    logic            offered_free;
    logic            sel;
    logic            offer_cmd_en;
    logic            offer_cmd;
    logic            rd_beat;

    // Only the offered client can be unbusy, and only while the RAM is idle.
    assign offered_free = (state == IDLE) && !br.busy && !rst;
    assign c0.busy      = !(offered_free && !offer);
    assign c1.busy      = !(offered_free && offer);

    assign sel          = (state == IDLE) ? offer : owner;
    assign offer_cmd_en = offer ? c1.cmd_en : c0.cmd_en;
    assign offer_cmd    = offer ? c1.cmd    : c0.cmd;

    assign br.cmd_en    = offered_free && offer_cmd_en;
    assign br.cmd       = sel ? c1.cmd       : c0.cmd;
    assign br.addr      = sel ? c1.addr      : c0.addr;
    assign br.wr_data   = sel ? c1.wr_data   : c0.wr_data;
    assign br.data_mask = sel ? c1.data_mask : c0.data_mask;

    // Stray beats outside a read burst are dropped rather than delivered to anyone.
    assign rd_beat          = (state == READ) && br.rd_data_valid && !rst;
    assign c0.rd_data_valid = rd_beat && !owner;
    assign c1.rd_data_valid = rd_beat && owner;
    assign c0.rd_data       = br.rd_data;
    assign c1.rd_data       = br.rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            offer <= 1'b0;
            owner <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!br.busy) begin
                        if (offer_cmd_en) begin
                            owner <= offer;
                            count <= '0;
                            state <= offer_cmd ? WRITE : READ;
                        end else begin
                            offer <= ~offer;
                        end
                    end
                end
                // Beat 0 left with the command, so only BURST_COUNT-1 beats remain here.
                WRITE: begin
                    if (count == LAST_WR) begin
                        state <= IDLE;
                        offer <= ~owner;
                        count <= '0;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                READ: begin
                    if (br.rd_data_valid) begin
                        if (count == LAST_RD) begin
                            state <= IDLE;
                            offer <= ~owner;
                            count <= '0;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter with a small behavioural BurstRAM behind it.
// The RAM model accepts one burst at a time and returns read beats after a short latency.
module tb_burst_ram_arbiter;
    localparam int DW = 64;
    localparam int AW = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    burst_ram_arbiter_if #(.DEPTH_BITWIDTH(AW), .DATA_BITWIDTH(DW)) c0_if ();
    burst_ram_arbiter_if #(.DEPTH_BITWIDTH(AW), .DATA_BITWIDTH(DW)) c1_if ();
    burst_ram_arbiter_if #(.DEPTH_BITWIDTH(AW), .DATA_BITWIDTH(DW)) br_if ();

    burst_ram_arbiter #(
        .DEPTH_BITWIDTH(AW),
        .DATA_BITWIDTH(DW),
        .BURST_COUNT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .c0  (c0_if),
        .c1  (c1_if),
        .br  (br_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]    mstate;
    logic [1:0]    mbeat;
    logic [AW-1:0] maddr;
    logic          mvalid;
    logic [DW-1:0] mdata;
    logic [DW-1:0] mem [0:1023];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [DW/8-1:0] mask);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < DW/8; b++)
            if (!mask[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    end

    // RAM model: busy for the whole burst, reads appear two cycles after the command.
    always @(posedge clk) begin
        if (rst) begin
            mstate <= 3'd0;
            mvalid <= 1'b0;
            mbeat  <= 2'd0;
        end else begin
            case (mstate)
                3'd0: begin
                    mvalid <= 1'b0;
                    if (br_if.cmd_en) begin
                        maddr <= br_if.addr;
                        if (br_if.cmd) begin
                            mem[{br_if.addr, 2'd0}] <= merge(mem[{br_if.addr, 2'd0}], br_if.wr_data, br_if.data_mask);
                            mbeat  <= 2'd1;
                            mstate <= 3'd1;
                        end else begin
                            mbeat  <= 2'd0;
                            mstate <= 3'd2;
                        end
                    end
                end
                3'd1: begin
                    mem[{maddr, mbeat}] <= merge(mem[{maddr, mbeat}], br_if.wr_data, br_if.data_mask);
                    mbeat <= mbeat + 2'd1;
                    if (mbeat == 2'd3) mstate <= 3'd0;
                end
                3'd2: mstate <= 3'd3;
                3'd3: begin
                    mvalid <= 1'b1;
                    mdata  <= mem[{maddr, mbeat}];
                    mbeat  <= mbeat + 2'd1;
                    if (mbeat == 2'd3) mstate <= 3'd4;
                end
                default: begin
                    mvalid <= 1'b0;
                    mstate <= 3'd0;
                end
            endcase
        end
    end

    assign br_if.busy          = (mstate != 3'd0);
    assign br_if.rd_data_valid = mvalid;
    assign br_if.rd_data       = mdata;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c0_if.cmd = 1'b0; c0_if.cmd_en = 1'b0; c0_if.addr = '0; c0_if.wr_data = '0; c0_if.data_mask = '0;
        c1_if.cmd = 1'b0; c1_if.cmd_en = 1'b0; c1_if.addr = '0; c1_if.wr_data = '0; c1_if.data_mask = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_offer(input int n);
        for (int i = 0; i < 20; i++) begin
            if ((n == 0 ? c0_if.busy : c1_if.busy) == 1'b0) begin
                total++;
                return;
            end
            step();
        end
        total++; bad++;
        $display("[TB] FAIL wait_offer_c%0d: busy=1 after 20 cycles, required 0", n);
    endtask

    // Observes up to 14 cycles of read beats for one client and checks order and ownership.
    task automatic collect_read(input int client, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                                input logic [DW-1:0] e2, input logic [DW-1:0] e3, input string name);
        logic [DW-1:0] exp_beats [4];
        int k;
        int stray;
        exp_beats[0] = e0; exp_beats[1] = e1; exp_beats[2] = e2; exp_beats[3] = e3;
        k = 0;
        stray = 0;
        for (int i = 0; i < 14; i++) begin
            if ((client == 0 ? c0_if.rd_data_valid : c1_if.rd_data_valid) === 1'b1) begin
                if (k < 4) begin
                    total++;
                    if ((client == 0 ? c0_if.rd_data : c1_if.rd_data) !== exp_beats[k]) begin
                        bad++;
                        $display("[TB] FAIL %s_beat%0d: got %h, required %h", name, k,
                                 (client == 0 ? c0_if.rd_data : c1_if.rd_data), exp_beats[k]);
                    end
                end
                k++;
            end
            if ((client == 0 ? c1_if.rd_data_valid : c0_if.rd_data_valid) !== 1'b0) stray++;
            step();
        end
        total++;
        if (k !== 4) begin
            bad++;
            $display("[TB] FAIL %s_beat_count: got %0d, required 4", name, k);
        end
        total++;
        if (stray !== 0) begin
            bad++;
            $display("[TB] FAIL %s_other_valid: got %0d pulses, required 0", name, stray);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({c0_if.busy, c1_if.busy, c0_if.rd_data_valid, c1_if.rd_data_valid, br_if.cmd_en} !== 5'b11000) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %b, required 11000",
                     {c0_if.busy, c1_if.busy, c0_if.rd_data_valid, c1_if.rd_data_valid, br_if.cmd_en});
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({c0_if.busy, c1_if.busy, br_if.cmd_en} !== ((i % 2 == 0) ? 3'b010 : 3'b100)) begin
                bad++;
                $display("[TB] FAIL reset_offer_cycle%0d: got busy0,busy1,cmd_en=%b, required %b", i + 1,
                         {c0_if.busy, c1_if.busy, br_if.cmd_en}, ((i % 2 == 0) ? 3'b010 : 3'b100));
            end
            step();
        end
    endtask

    task automatic test_illegal_strobe();
        idle_inputs();
        do_reset();
        c1_if.cmd = 1'b1; c1_if.cmd_en = 1'b1; c1_if.addr = 8'd9;
        #1;
        total++;
        if ({c0_if.busy, c1_if.busy, br_if.cmd_en} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL illegal_strobe_blocked: got busy0,busy1,cmd_en=%b, required 010",
                     {c0_if.busy, c1_if.busy, br_if.cmd_en});
        end
        step();
        c1_if.cmd_en = 1'b0;
        #1;
        total++;
        if ({c0_if.busy, c1_if.busy, br_if.cmd_en} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL illegal_strobe_no_grant: got busy0,busy1,cmd_en=%b, required 100",
                     {c0_if.busy, c1_if.busy, br_if.cmd_en});
        end
        step();
        total++;
        if ({c0_if.busy, c1_if.busy} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL illegal_strobe_still_idle: got busy0,busy1=%b, required 01", {c0_if.busy, c1_if.busy});
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] beats [4];
        beats[0] = {8{8'h11}}; beats[1] = {8{8'h22}}; beats[2] = {8{8'h33}}; beats[3] = {8{8'h44}};
        idle_inputs();
        wait_offer(0);
        c0_if.cmd = 1'b1; c0_if.cmd_en = 1'b1; c0_if.addr = 8'd5; c0_if.wr_data = beats[0]; c0_if.data_mask = '0;
        #1;
        total++;
        if ({br_if.cmd_en, br_if.cmd, br_if.addr, br_if.wr_data} !== {1'b1, 1'b1, 8'd5, beats[0]}) begin
            bad++;
            $display("[TB] FAIL write_cmd: got en=%b cmd=%b addr=%0d data=%h, required en=1 cmd=1 addr=5 data=%h",
                     br_if.cmd_en, br_if.cmd, br_if.addr, br_if.wr_data, beats[0]);
        end
        for (int b = 1; b < 4; b++) begin
            step();
            c0_if.cmd_en = 1'b0;
            c0_if.wr_data = beats[b];
            #1;
            total++;
            if ({br_if.cmd_en, br_if.wr_data, c1_if.busy} !== {1'b0, beats[b], 1'b1}) begin
                bad++;
                $display("[TB] FAIL write_beat%0d: got en=%b data=%h c1_busy=%b, required en=0 data=%h c1_busy=1",
                         b, br_if.cmd_en, br_if.wr_data, c1_if.busy, beats[b]);
            end
        end
        step();
        total++;
        if ({c0_if.busy, c1_if.busy} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL write_then_offer_c1: got busy0,busy1=%b, required 10", {c0_if.busy, c1_if.busy});
        end
        c1_if.cmd = 1'b0; c1_if.cmd_en = 1'b1; c1_if.addr = 8'd5;
        #1;
        total++;
        if ({br_if.cmd_en, br_if.cmd, br_if.addr} !== {1'b1, 1'b0, 8'd5}) begin
            bad++;
            $display("[TB] FAIL read_cmd_c1: got en=%b cmd=%b addr=%0d, required en=1 cmd=0 addr=5",
                     br_if.cmd_en, br_if.cmd, br_if.addr);
        end
        step();
        c1_if.cmd_en = 1'b0;
        #1;
        collect_read(1, beats[0], beats[1], beats[2], beats[3], "read_c1");
    endtask

    task automatic test_mask();
        idle_inputs();
        wait_offer(0);
        c0_if.cmd = 1'b1; c0_if.cmd_en = 1'b1; c0_if.addr = 8'd5;
        c0_if.wr_data = {8{8'hAA}}; c0_if.data_mask = 8'h0F;
        step();
        c0_if.cmd_en = 1'b0;
        c0_if.wr_data = {8{8'hEE}}; c0_if.data_mask = 8'hFF;
        step();
        step();
        step();
        idle_inputs();
        wait_offer(1);
        c1_if.cmd = 1'b0; c1_if.cmd_en = 1'b1; c1_if.addr = 8'd5;
        step();
        c1_if.cmd_en = 1'b0;
        #1;
        collect_read(1, 64'hAAAAAAAA11111111, {8{8'h22}}, {8{8'h33}}, {8{8'h44}}, "mask_read");
    endtask

    task automatic test_back_to_back();
        int grants;
        int v0;
        int v1;
        int wrong;
        logic cur_owner;
        idle_inputs();
        c0_if.cmd_en = 1'b1; c0_if.addr = 8'd5;
        c1_if.cmd_en = 1'b1; c1_if.addr = 8'd6;
        do_reset();
        grants = 0; v0 = 0; v1 = 0; wrong = 0; cur_owner = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (br_if.cmd_en === 1'b1) begin
                total++;
                if (br_if.addr !== ((grants % 2 == 0) ? 8'd5 : 8'd6)) begin
                    bad++;
                    $display("[TB] FAIL b2b_grant%0d: got addr %0d, required %0d", grants, br_if.addr,
                             ((grants % 2 == 0) ? 5 : 6));
                end
                cur_owner = (grants % 2 == 1);
                grants++;
            end
            if (c0_if.rd_data_valid === 1'b1) begin v0++; if (cur_owner != 1'b0) wrong++; end
            if (c1_if.rd_data_valid === 1'b1) begin v1++; if (cur_owner != 1'b1) wrong++; end
            if (grants >= 4 && v0 + v1 >= 16) break;
            step();
            if (grants >= 4) begin
                c0_if.cmd_en = 1'b0;
                c1_if.cmd_en = 1'b0;
            end
            #1;
        end
        idle_inputs();
        total++;
        if ({grants, v0, v1, wrong} !== {32'd4, 32'd8, 32'd8, 32'd0}) begin
            bad++;
            $display("[TB] FAIL b2b_totals: got grants=%0d v0=%0d v1=%0d wrong=%0d, required 4 8 8 0",
                     grants, v0, v1, wrong);
        end
    endtask

    task automatic test_reset_mid_burst();
        int seen;
        idle_inputs();
        do_reset();
        c0_if.cmd = 1'b0; c0_if.cmd_en = 1'b1; c0_if.addr = 8'd5;
        seen = 0;
        for (int i = 0; i < 12 && seen < 2; i++) begin
            step();
            c0_if.cmd_en = 1'b0;
            #1;
            if (c0_if.rd_data_valid === 1'b1) seen++;
        end
        total++;
        if (seen !== 2) begin
            bad++;
            $display("[TB] FAIL midrst_prebeats: got %0d, required 2", seen);
        end
        step();
        rst = 1'b1;
        #1;
        total++;
        if ({c0_if.busy, c1_if.busy, c0_if.rd_data_valid, c1_if.rd_data_valid} !== 4'b1100) begin
            bad++;
            $display("[TB] FAIL midrst_during: got busy0,busy1,v0,v1=%b, required 1100",
                     {c0_if.busy, c1_if.busy, c0_if.rd_data_valid, c1_if.rd_data_valid});
        end
        step();
        rst = 1'b0;
        #1;
        total++;
        if ({c0_if.busy, c1_if.busy, c0_if.rd_data_valid} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL midrst_after: got busy0,busy1,v0=%b, required 010",
                     {c0_if.busy, c1_if.busy, c0_if.rd_data_valid});
        end
        c0_if.cmd_en = 1'b1;
        step();
        c0_if.cmd_en = 1'b0;
        #1;
        collect_read(0, 64'hAAAAAAAA11111111, {8{8'h22}}, {8{8'h33}}, {8{8'h44}}, "midrst_read");
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_illegal_strobe();
        test_write_read();
        test_mask();
        test_back_to_back();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
